// File: rtl/tanh_2d_parallel_filters.sv
// Element-wise tanh (shift-add piecewise-linear) over filter_size maps of image_size x image_size float32.
// Define TANH_PIPE_EN to register between classify/fixed-point compute and the float pack (latency 2).
module tanh_2d_parallel_filters #(
    parameter int unsigned datawidth   = 32,
    parameter int unsigned image_size  = 4,
    parameter int unsigned filter_size = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic [datawidth-1:0] in_tanh  [filter_size][image_size][image_size],
    output logic [datawidth-1:0] out_tanh [filter_size][image_size][image_size]
);

    localparam int unsigned FX_W = 25;  // U2.23

    localparam logic [30:0]     HALF_MAG = 31'h3F00_0000;  // 0.5
    localparam logic [30:0]     KNEE_MAG = 31'h3F98_0000;  // 1.1875
    localparam logic [30:0]     SAT_MAG  = 31'h4020_0000;  // 2.5
    localparam logic [30:0]     INF_MAG  = 31'h7F80_0000;
    localparam logic [FX_W-1:0] SEG1_OFS = 25'h020_0000;   // 0.25
    localparam logic [FX_W-1:0] SEG2_OFS = 25'h058_0000;   // 0.6875

    typedef enum logic [1:0] {
        CLS_PASS = 2'd0,
        CLS_FIX  = 2'd1,
        CLS_ONE  = 2'd2,
        CLS_NAN  = 2'd3
    } cls_e;

    // payload holds the raw magnitude for PASS, the U2.23 result for FIX
    typedef struct packed {
        cls_e        cls;
        logic        sign;
        logic [30:0] payload;
    } stage_t;

    function automatic stage_t classify(input logic [31:0] x);
        stage_t          st;
        logic [FX_W-1:0] a_fx;
        logic [FX_W-1:0] f_fx;
        a_fx       = '0;
        f_fx       = '0;
        st.cls     = CLS_PASS;
        st.sign    = x[31];
        st.payload = x[30:0];
        // Only exponents 126..128 reach the fixed-point path; shift the significand into U2.23
        case (x[30:23])
            8'd126:  a_fx = FX_W'({1'b1, x[22:1]});
            8'd127:  a_fx = FX_W'({1'b1, x[22:0]});
            default: a_fx = {1'b1, x[22:0], 1'b0};
        endcase
        if (x[30:0] > INF_MAG) begin
            st.cls = CLS_NAN;
        end else if (x[30:0] >= SAT_MAG) begin
            st.cls = CLS_ONE;
        end else if (x[30:0] >= HALF_MAG) begin
            st.cls = CLS_FIX;
            if (x[30:0] >= KNEE_MAG) begin
                f_fx = (a_fx >> 3) + SEG2_OFS;
            end else begin
                f_fx = (a_fx >> 1) + SEG1_OFS;
            end
            st.payload = 31'(f_fx);
        end
        return st;
    endfunction

    // FIX results lie in [0.5, 1.0): bit 22 is the hidden one, exponent is fixed at 126
    function automatic logic [31:0] pack(input stage_t st);
        logic [31:0] y;
        case (st.cls)
            CLS_FIX: y = {st.sign, 8'd126, st.payload[21:0], 1'b0};
            CLS_ONE: y = {st.sign, 31'h3F80_0000};
            CLS_NAN: y = 32'h7FC0_0000;
            default: y = {st.sign, st.payload};
        endcase
        return y;
    endfunction

    for (genvar f = 0; f < int'(filter_size); f++) begin : g_filt
        for (genvar r = 0; r < int'(image_size); r++) begin : g_row
            for (genvar c = 0; c < int'(image_size); c++) begin : g_col
                logic [datawidth-1:0] out_d;
                logic [datawidth-1:0] out_q;

`ifdef TANH_PIPE_EN
                stage_t st_d;
                stage_t st_q;

                assign st_d = classify(32'(in_tanh[f][r][c]));

                always_ff @(posedge clk or posedge reset) begin
                    if (reset) begin
                        st_q <= '0;
                    end else if (enable) begin
                        st_q <= st_d;
                    end
                end

                assign out_d = datawidth'(pack(st_q));
`else
                assign out_d = datawidth'(pack(classify(32'(in_tanh[f][r][c]))));
`endif

                always_ff @(posedge clk or posedge reset) begin
                    if (reset) begin
                        out_q <= '0;
                    end else if (enable) begin
                        out_q <= out_d;
                    end
                end

                assign out_tanh[f][r][c] = out_q;
            end
        end
    end

endmodule

// File: tb/tb_tanh_2d_parallel_filters.sv
// Randomized scoreboard bench for tanh_2d_parallel_filters; reference model evaluates the
// piecewise-linear tanh with real arithmetic. Honours TANH_PIPE_EN for the two-stage build.
module tb_tanh_2d_parallel_filters;

    localparam int unsigned DW = 32;
    localparam int unsigned IS = 4;
    localparam int unsigned FS = 2;
    localparam int unsigned N  = FS * IS * IS;

    typedef logic [N-1:0][31:0] frame_t;

    localparam logic [31:0] DIR_IN [16] = '{
        32'h3F000000, 32'h3F200000, 32'h3F300000, 32'h3F400000,
        32'h3F800000, 32'h40000000, 32'hBF800000, 32'h3E800000,
        32'h80000000, 32'h40400000, 32'hC0400000, 32'h7F800000,
        32'hFF800000, 32'h7FC12345, 32'h40200000, 32'h401FFFFF
    };
    localparam logic [31:0] DIR_OUT [16] = '{
        32'h3F000000, 32'h3F100000, 32'h3F180000, 32'h3F200000,
        32'h3F400000, 32'h3F700000, 32'hBF400000, 32'h3E800000,
        32'h80000000, 32'h3F800000, 32'hBF800000, 32'h3F800000,
        32'hBF800000, 32'h7FC00000, 32'h3F800000, 32'h3F7FFFFE
    };

    logic          clk    = 1'b0;
    logic          reset  = 1'b1;
    logic          enable = 1'b0;
    logic [DW-1:0] in_tanh  [FS][IS][IS];
    logic [DW-1:0] out_tanh [FS][IS][IS];

    int     checks = 0;
    int     errors = 0;
    frame_t exp_q[$];
    frame_t exp_mid = '0;
    frame_t exp_out = '0;

    always #5 clk = ~clk;

    tanh_2d_parallel_filters #(
        .datawidth  (DW),
        .image_size (IS),
        .filter_size(FS)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .enable  (enable),
        .in_tanh (in_tanh),
        .out_tanh(out_tanh)
    );

    // Reference: evaluate the segment formulas on the real value, truncating to U2.23
    function automatic logic [31:0] ref_tanh(input logic [31:0] x);
        logic        sign;
        int          e;
        real         a;
        longint      fx;
        longint      y;
        logic [22:0] m;
        sign = x[31];
        e    = int'(x[30:23]);
        if (e == 255) return (x[22:0] != 23'd0) ? 32'h7FC00000 : {sign, 31'h3F800000};
        if (e < 126) return x;
        a = (8388608.0 + real'(int'(x[22:0]))) * (2.0 ** (e - 150));
        if (a >= 2.5) return {sign, 31'h3F800000};
        fx = longint'($floor(a * 8388608.0));
        if (a < 1.1875) y = fx / 2 + 64'sd2097152;
        else            y = fx / 8 + 64'sd5767168;
        m = 23'(2 * y - 64'sd8388608);
        return {sign, 8'd126, m};
    endfunction

    function automatic frame_t ref_frame(input frame_t fr);
        frame_t ex;
        for (int k = 0; k < int'(N); k++) ex[k] = ref_tanh(fr[k]);
        return ex;
    endfunction

    function automatic logic [31:0] rand_val();
        case ($urandom_range(0, 9))
            0:       return $urandom;
            1:       return {1'($urandom), 8'hFF, ($urandom_range(0, 1) != 0) ? 23'($urandom) : 23'd0};
            2:       return {1'($urandom), 8'($urandom_range(0, 125)), 23'($urandom)};
            default: return {1'($urandom), 8'($urandom_range(125, 129)), 23'($urandom)};
        endcase
    endfunction

    function automatic frame_t rand_frame();
        frame_t fr;
        for (int k = 0; k < int'(N); k++) fr[k] = rand_val();
        return fr;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input frame_t fr, input logic en);
        for (int f = 0; f < int'(FS); f++)
            for (int r = 0; r < int'(IS); r++)
                for (int c = 0; c < int'(IS); c++)
                    in_tanh[f][r][c] = fr[f*IS*IS + r*IS + c];
        enable = en;
    endtask

    task automatic issue(input frame_t fr, input frame_t ex);
        drive(fr, 1'b1);
        exp_q.push_back(ex);
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // Scoreboard advance: each enabled edge consumes one issued frame
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            exp_q.delete();
            exp_mid = '0;
            exp_out = '0;
        end else if (enable) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL scoreboard_underflow queue_size 0 expected >= 1 at %0t", $time);
            end else begin
`ifdef TANH_PIPE_EN
                exp_out = exp_mid;
                exp_mid = exp_q.pop_front();
`else
                exp_out = exp_q.pop_front();
`endif
            end
        end
    end

    always @(negedge clk) begin
        for (int f = 0; f < int'(FS); f++)
            for (int r = 0; r < int'(IS); r++)
                for (int c = 0; c < int'(IS); c++)
                    chk($sformatf("out[%0d][%0d][%0d]", f, r, c), out_tanh[f][r][c],
                        exp_out[f*IS*IS + r*IS + c]);
    end

    initial begin
        frame_t fr;
        frame_t ex;

        for (int k = 0; k < int'(N); k++) fr[k] = $urandom | 32'h1;
        drive(fr, 1'b1);
        repeat (3) step();
        reset = 1'b0;
        drive(fr, 1'b0);
        repeat (3) step();

        for (int k = 0; k < int'(N); k++) begin
            fr[k] = DIR_IN[k % 16];
            ex[k] = DIR_OUT[k % 16];
        end
        issue(fr, ex);
        step();
        drive(rand_frame(), 1'b0);
        step();
        drive(rand_frame(), 1'b0);
        step();

        // Permuted placement catches cross-element leakage
        for (int k = 0; k < int'(N); k++) begin
            fr[k] = DIR_IN[(k * 5 + 3) % 16];
            ex[k] = DIR_OUT[(k * 5 + 3) % 16];
        end
        fr[4] = 32'h3F800000; ex[4] = 32'h3F400000;
        fr[5] = 32'h3F000000; ex[5] = 32'h3F000000;
        fr[6] = 32'h3F200000; ex[6] = 32'h3F100000;
        fr[7] = 32'h3F200000; ex[7] = 32'h3F100000;
        issue(fr, ex);
        step();

        for (int i = 0; i < 200; i++) begin
            if (i == 90) begin
                reset  = 1'b1;
                enable = 1'b0;
                #1;
                for (int f = 0; f < int'(FS); f++)
                    for (int r = 0; r < int'(IS); r++)
                        for (int c = 0; c < int'(IS); c++)
                            chk($sformatf("async_rst[%0d][%0d][%0d]", f, r, c), out_tanh[f][r][c], 32'h0);
                step();
                reset = 1'b0;
            end
            fr = rand_frame();
            if (i > 195 || $urandom_range(0, 9) < 7) issue(fr, ref_frame(fr));
            else drive(fr, 1'b0);
            step();
        end

        drive(rand_frame(), 1'b0);
        repeat (3) step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
